// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types and constants for the I2C job arbiter slice.
//   state_t      - arbiter FSM states
//   N_REQ, CFG_W - requester count and per-requester config width
//   CFG_ONE_RST / CFG_TWO_RST - config pair presented to the core after reset
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam int N_REQ = 2;
    localparam int CFG_W = 16;

    localparam logic [7:0] CFG_ONE_RST = 8'hD3;
    localparam logic [7:0] CFG_TWO_RST = 8'h83;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant.
//   clk, reset - clock, asynchronous active-low reset
//   req        - request vector (bit i = requester i)
//   advance    - strobe: the job for requester 'last' is finished
//   last       - index of the requester that was just served
//   grant      - combinational winner index (meaningful while |req)
module rr_arbiter_2
    import i2c_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    input  logic             last,
    output logic             grant
);

    // ptr names the requester that wins a tie
    logic ptr;

    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ptr;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~last;
        end
    end

endmodule

// File: rtl/i2c_job_arbiter.sv
// i2c_job_arbiter: shares one byte-pair I2C core between two requesters
// (0 = register front end, 1 = autopoll engine).
//   clk, reset          - clock, asynchronous active-low reset
//   req_valid/req_cfg   - job requests and per-requester config pairs
//   req_ready           - one-cycle accept pulse to the granted requester
//   rsp_valid/rsp_err/rsp_timeout/rsp_data - one-cycle completion response
//   busy                - high whenever a job is in flight
//   i2c_begin/i2c_cfg_* - drive to the core; begin held for each attempt
//   i2c_byte_*/i2c_error/i2c_done - results from the core
// Optional: define I2C_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYC.
module i2c_job_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int MAX_RETRY   = 2,
    parameter int GAP_CYC     = 1000,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_cfg,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic        i2c_begin,
    output logic [7:0]  i2c_cfg_one,
    output logic [7:0]  i2c_cfg_two,
    input  logic [7:0]  i2c_byte_one,
    input  logic [7:0]  i2c_byte_two,
    input  logic        i2c_error,
    input  logic        i2c_done
);

    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    state_t           state, state_nxt;
    logic             grant, grant_q;
    logic [CFG_W-1:0] cfg_sel;
    logic [RTY_W-1:0] retry_q;
    logic [GAP_W-1:0] gap_q;
    logic [7:0]       cfg_one_q, cfg_two_q;
    logic [1:0]       ready_q;
    logic             begin_q, err_q;
    logic [15:0]      data_q;
    logic             tmo_hit;

    function automatic logic [RTY_W-1:0] retry_inc(input logic [RTY_W-1:0] v);
        return (v == {RTY_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [GAP_W-1:0] gap_inc(input logic [GAP_W-1:0] v);
        return (v == {GAP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    rr_arbiter_2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (state == S_RESP),
        .last    (grant_q),
        .grant   (grant)
    );

    assign cfg_sel = grant ? req_cfg[31:16] : req_cfg[15:0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|req_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                // done has priority over a coincident timeout
                if (i2c_done) begin
                    if (i2c_error && (retry_q < RTY_W'(MAX_RETRY))) state_nxt = S_GAP;
                    else                                             state_nxt = S_RESP;
                end else if (tmo_hit) begin
                    state_nxt = S_RESP;
                end
            end
            S_GAP:   if (gap_q == GAP_W'(GAP_CYC - 1)) state_nxt = S_ISSUE;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            grant_q   <= 1'b0;
            ready_q   <= 2'b00;
            begin_q   <= 1'b0;
            retry_q   <= '0;
            gap_q     <= '0;
            cfg_one_q <= CFG_ONE_RST;
            cfg_two_q <= CFG_TWO_RST;
            err_q     <= 1'b0;
            data_q    <= 16'h0000;
        end else begin
            state   <= state_nxt;
            ready_q <= 2'b00;
            // begin rises one cycle after ISSUE and drops the cycle after WAIT ends
            begin_q <= (state == S_ISSUE) || (state == S_WAIT && state_nxt == S_WAIT);
            gap_q   <= (state == S_GAP) ? gap_inc(gap_q) : '0;

            if (state == S_IDLE && |req_valid) begin
                grant_q        <= grant;
                ready_q[grant] <= 1'b1;
                cfg_one_q      <= cfg_sel[15:8];
                cfg_two_q      <= cfg_sel[7:0];
                retry_q        <= '0;
            end

            if (state == S_WAIT) begin
                if (i2c_done) begin
                    err_q  <= i2c_error;
                    data_q <= {i2c_byte_one, i2c_byte_two};
                    if (state_nxt == S_GAP) retry_q <= retry_inc(retry_q);
                end else if (tmo_hit) begin
                    err_q  <= 1'b1;
                    data_q <= 16'hFFFF;
                end
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_q;

    function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] v);
        return (v == {TMO_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign tmo_hit = (state == S_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if (state == S_ISSUE)     tmo_cnt_q <= '0;
            else if (state == S_WAIT) tmo_cnt_q <= tmo_inc(tmo_cnt_q);

            if (state == S_WAIT) begin
                if (i2c_done)     tmo_q <= 1'b0;
                else if (tmo_hit) tmo_q <= 1'b1;
            end
        end
    end

    assign rsp_timeout = tmo_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
    assign tmo_hit        = 1'b0;
    assign rsp_timeout    = 1'b0;
`endif

    assign req_ready   = ready_q;
    assign rsp_valid   = (state == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_err     = err_q;
    assign rsp_data    = data_q;
    assign busy        = (state != S_IDLE);
    assign i2c_begin   = begin_q;
    assign i2c_cfg_one = cfg_one_q;
    assign i2c_cfg_two = cfg_two_q;

endmodule

// File: tb/tb_i2c_job_arbiter.sv
module tb_i2c_job_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [31:0] req_cfg;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [15:0] rsp_data;
    logic        busy;
    logic        i2c_begin;
    logic [7:0]  i2c_cfg_one;
    logic [7:0]  i2c_cfg_two;
    logic [7:0]  i2c_byte_one;
    logic [7:0]  i2c_byte_two;
    logic        i2c_error;
    logic        i2c_done;

    int checks   = 0;
    int failures = 0;
    int rises    = 0;
    logic begin_d = 1'b0;
    int n;
    int r0;

    i2c_job_arbiter #(
        .MAX_RETRY   (2),
        .GAP_CYC     (5),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_cfg      (req_cfg),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_timeout  (rsp_timeout),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .i2c_begin    (i2c_begin),
        .i2c_cfg_one  (i2c_cfg_one),
        .i2c_cfg_two  (i2c_cfg_two),
        .i2c_byte_one (i2c_byte_one),
        .i2c_byte_two (i2c_byte_two),
        .i2c_error    (i2c_error),
        .i2c_done     (i2c_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        begin_d <= i2c_begin;
        if (i2c_begin && !begin_d) rises <= rises + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_attempt(input logic err, input logic [7:0] b1, input logic [7:0] b2);
        i2c_error    = err;
        i2c_byte_one = b1;
        i2c_byte_two = b2;
        i2c_done     = 1'b1;
        tick();
        i2c_done  = 1'b0;
        i2c_error = 1'b0;
    endtask

    task automatic wait_begin(output int cnt);
        cnt = 0;
        while (i2c_begin !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        req_valid    = 2'b00;
        req_cfg      = 32'h3CC3_1357;
        i2c_byte_one = 8'h00;
        i2c_byte_two = 8'h00;
        i2c_error    = 1'b0;
        i2c_done     = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    32'(busy),        32'h0);
        chk("rst_ready",   32'(req_ready),   32'h0);
        chk("rst_rspv",    32'(rsp_valid),   32'h0);
        chk("rst_begin",   32'(i2c_begin),   32'h0);
        chk("rst_cfg_one", 32'(i2c_cfg_one), 32'hD3);
        chk("rst_cfg_two", 32'(i2c_cfg_two), 32'h83);
        chk("rst_data",    32'(rsp_data),    32'h0);
        reset = 1'b1;

        // done while idle is ignored
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        chk("idle_done_busy", 32'(busy),      32'h0);
        chk("idle_done_rspv", 32'(rsp_valid), 32'h0);

        // single job on requester 0
        req_valid = 2'b01;
        tick();
        chk("j1_ready",   32'(req_ready),   32'h1);
        chk("j1_busy",    32'(busy),        32'h1);
        chk("j1_begin0",  32'(i2c_begin),   32'h0);
        chk("j1_cfg_one", 32'(i2c_cfg_one), 32'h13);
        chk("j1_cfg_two", 32'(i2c_cfg_two), 32'h57);
        req_valid = 2'b00;
        tick();
        chk("j1_ready_off", 32'(req_ready), 32'h0);
        chk("j1_begin1",    32'(i2c_begin), 32'h1);
        repeat (48) tick();
        chk("j1_begin_held", 32'(i2c_begin), 32'h1);
        chk("j1_no_rsp",     32'(rsp_valid), 32'h0);
        finish_attempt(1'b0, 8'h12, 8'h34);
        chk("j1_rspv",  32'(rsp_valid),   32'h1);
        chk("j1_data",  32'(rsp_data),    32'h1234);
        chk("j1_err",   32'(rsp_err),     32'h0);
        chk("j1_tmo",   32'(rsp_timeout), 32'h0);
        chk("j1_bdrop", 32'(i2c_begin),   32'h0);
        tick();
        chk("j1_rspv_off", 32'(rsp_valid), 32'h0);
        chk("j1_idle",     32'(busy),      32'h0);

        // round robin on ties
        do_reset();
        req_valid = 2'b11;
        tick();
        chk("rr1_ready", 32'(req_ready),   32'h1);
        chk("rr1_cfg",   32'(i2c_cfg_one), 32'h13);
        req_valid = 2'b10;
        tick();
        finish_attempt(1'b0, 8'h00, 8'h01);
        chk("rr1_rspv", 32'(rsp_valid), 32'h1);
        tick();
        chk("rr2_wait", 32'(req_ready), 32'h0);
        tick();
        chk("rr2_ready",   32'(req_ready),   32'h2);
        chk("rr2_cfg_one", 32'(i2c_cfg_one), 32'h3C);
        chk("rr2_cfg_two", 32'(i2c_cfg_two), 32'hC3);
        req_valid = 2'b00;
        tick();
        finish_attempt(1'b0, 8'h56, 8'h78);
        chk("rr2_rspv", 32'(rsp_valid), 32'h2);
        chk("rr2_data", 32'(rsp_data),  32'h5678);
        req_valid = 2'b11;
        tick();
        tick();
        chk("rr3_ready", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        tick();
        finish_attempt(1'b0, 8'h9A, 8'hBC);
        chk("rr3_rspv", 32'(rsp_valid), 32'h1);
        tick();

        // error on every attempt: three attempts then failure
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        r0 = rises;
        tick();
        finish_attempt(1'b1, 8'hAA, 8'hBB);
        chk("ra_gap_begin", 32'(i2c_begin), 32'h0);
        chk("ra_gap_rspv",  32'(rsp_valid), 32'h0);
        wait_begin(n);
        chk("ra_gap1_len", 32'(n), 32'd6);
        finish_attempt(1'b1, 8'hAA, 8'hBB);
        wait_begin(n);
        chk("ra_gap2_len", 32'(n), 32'd6);
        finish_attempt(1'b1, 8'hCC, 8'hDD);
        chk("ra_rspv",   32'(rsp_valid),  32'h1);
        chk("ra_err",    32'(rsp_err),    32'h1);
        chk("ra_data",   32'(rsp_data),   32'hCCDD);
        chk("ra_begins", 32'(rises - r0), 32'd3);
        tick();

        // error then success
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        r0 = rises;
        tick();
        finish_attempt(1'b1, 8'h11, 8'h22);
        wait_begin(n);
        chk("rb_gap_len", 32'(n), 32'd6);
        finish_attempt(1'b0, 8'hAB, 8'hCD);
        chk("rb_rspv",   32'(rsp_valid),  32'h1);
        chk("rb_err",    32'(rsp_err),    32'h0);
        chk("rb_data",   32'(rsp_data),   32'hABCD);
        chk("rb_begins", 32'(rises - r0), 32'd2);
        tick();

        // reset mid-WAIT aborts the job, pending request survives
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        tick();
        tick();
        chk("ar_begin_pre", 32'(i2c_begin), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_begin", 32'(i2c_begin),   32'h0);
        chk("ar_busy",  32'(busy),        32'h0);
        chk("ar_cfg",   32'(i2c_cfg_one), 32'hD3);
        tick();
        tick();
        chk("ar_no_rsp", 32'(rsp_valid), 32'h0);
        reset = 1'b1;
        tick();
        chk("ar_ready1", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        tick();
        finish_attempt(1'b0, 8'h55, 8'h66);
        chk("ar_rspv", 32'(rsp_valid), 32'h2);
        tick();

`ifdef I2C_ARB_TIMEOUT_EN
        // no done: WAIT bounded at 100 cycles
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        n = 0;
        while (rsp_valid === 2'b00 && n < 200) begin
            tick();
            n++;
        end
        chk("to_len",   32'(n),           32'd100);
        chk("to_rspv",  32'(rsp_valid),   32'h1);
        chk("to_flag",  32'(rsp_timeout), 32'h1);
        chk("to_err",   32'(rsp_err),     32'h1);
        chk("to_data",  32'(rsp_data),    32'hFFFF);
        chk("to_begin", 32'(i2c_begin),   32'h0);
        tick();
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        chk("to_late_busy", 32'(busy),      32'h0);
        chk("to_late_rspv", 32'(rsp_valid), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
